// File: rtl/alu_req_arbiter_pkg.sv
// alu_arb_pkg: shared types and widths for the ALU request arbiter.
package alu_arb_pkg;

    localparam int OPC_W = 3;
    localparam int OPD_W = 4;
    localparam int RES_W = 8;

    // Opcodes at or above this value are compares; below are arithmetic.
    localparam logic [OPC_W-1:0] OPC_CMP_MIN = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester + response bus of alu_req_arbiter.
// slave = arbiter side, master = requester/consumer side.
interface alu_req_arbiter_if #(
    parameter int N_REQ = 2
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]                   req_valid;
    logic [N_REQ-1:0]                   req_ready;
    logic [N_REQ*alu_arb_pkg::OPC_W-1:0] req_opc;
    logic [N_REQ*alu_arb_pkg::OPD_W-1:0] req_a;
    logic [N_REQ*alu_arb_pkg::OPD_W-1:0] req_b;

    logic                               rsp_valid;
    logic                               rsp_ready;
    logic [ID_W-1:0]                    rsp_id;
    logic [alu_arb_pkg::RES_W-1:0]      rsp_data;

    modport slave (
        input  req_valid, req_opc, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport master (
        output req_valid, req_opc, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface

// File: rtl/alu_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Picks the first asserted
// request at or after the pointer, wrapping N-1 -> 0.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_any,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    logic w_found;
    int   w_j;

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        o_any   = |i_req;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found    = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU/compare datapath between
// N_REQ requesters. Round-robin grant, one operation in flight, result
// returned tagged with the requester id over a valid/ready channel.
// Optional build macro ALU_ARB_PERF_EN adds per-requester grant counters
// (o_perf_cnt) and a busy flag (o_perf_busy).
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DP_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    alu_req_arbiter_if.slave bus,
    output logic [OPC_W-1:0] o_dp_opc,
    output logic [OPD_W-1:0] o_dp_a,
    output logic [OPD_W-1:0] o_dp_b,
    input  logic [RES_W-1:0] i_dp_c
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [N_REQ*16-1:0] o_perf_cnt,
    output logic                o_perf_busy
`endif
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_WAIT = 2'(WAIT);
    localparam logic [1:0] S_CAPT = 2'(CAPT);
    localparam logic [1:0] S_RESP = 2'(RESP);

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_gid;
    logic [CNT_W-1:0] r_cnt;
    logic [OPC_W-1:0] r_dp_opc;
    logic [OPD_W-1:0] r_dp_a;
    logic [OPD_W-1:0] r_dp_b;
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [RES_W-1:0] r_rsp_data;

    logic             w_any;
    logic [N_REQ-1:0] w_gnt;
    logic [ID_W-1:0]  w_idx;
    logic [N_REQ-1:0] w_req_ready;
    logic [OPC_W-1:0] w_sel_opc;
    logic [OPD_W-1:0] w_sel_a;
    logic [OPD_W-1:0] w_sel_b;
    logic [ID_W-1:0]  w_ptr_next;

    rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    // Grant strobe is only offered while idle; operands come from the winner.
    always_comb begin
        w_req_ready = (r_state == S_IDLE) ? w_gnt : '0;
        w_sel_opc   = bus.req_opc[int'(w_idx)*OPC_W +: OPC_W];
        w_sel_a     = bus.req_a[int'(w_idx)*OPD_W +: OPD_W];
        w_sel_b     = bus.req_b[int'(w_idx)*OPD_W +: OPD_W];
        w_ptr_next  = (r_gid == ID_W'(N_REQ-1)) ? '0 : r_gid + 1'b1;
    end

    // Issue / wait / capture / respond sequencer; dp_* only change on issue.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_cnt       <= '0;
            r_dp_opc    <= '0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_dp_opc <= w_sel_opc;
                        r_dp_a   <= w_sel_a;
                        r_dp_b   <= w_sel_b;
                        r_gid    <= w_idx;
                        r_cnt    <= '0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(DP_LAT-1)) begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    r_rsp_data  <= i_dp_c;
                    r_rsp_id    <= r_gid;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Pointer advances only once the result has been taken,
                    // and no grant is made on the handshake cycle itself.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign o_dp_opc      = r_dp_opc;
    assign o_dp_a        = r_dp_a;
    assign o_dp_b        = r_dp_b;

`ifdef ALU_ARB_PERF_EN
    for (genvar g = 0; g < N_REQ; g++) begin : g_perf
        logic [15:0] r_grants;

        // Saturating count of accepted requests for requester g.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_grants <= '0;
            end else if (w_req_ready[g] && (r_grants != 16'hFFFF)) begin
                r_grants <= r_grants + 16'd1;
            end
        end

        assign o_perf_cnt[g*16 +: 16] = r_grants;
    end

    assign o_perf_busy = (r_state != S_IDLE);
`endif

endmodule
